dbg_ctrl: RTL
=============

# dbg_ctrl

Run/halt/step debug controller for the single-cycle CPU core. It gates CPU progress through a clock-enable (`cpu_en`) that qualifies the PC update and register-file write. It stops execution on a PC breakpoint and sequences a full 32-register dump through the core's `reg_sel`/`reg_data` debug port. It sits between the board-level debug inputs and the CPU top level.

## Interface
Parameters:
- `CNT_W`, default 32, width of the retired-instruction counter.

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1, reset; synchronous, active-high.
- `run`, in, 1, single-cycle pulse: start free-running.
- `step`, in, 1, single-cycle pulse: execute exactly one instruction.
- `halt`, in, 1, single-cycle pulse: stop free-running.
- `dump`, in, 1, single-cycle pulse: dump registers 0..31.
- `bp_en`, in, 1, breakpoint enable.
- `bp_addr`, in, 32, breakpoint PC.
- `PC`, in, 32, current PC from the core.
- `reg_data`, in, 32, selected register value from the core (combinational on `reg_sel`).
- `cpu_en`, out, 1, core enable; the core retires one instruction in every cycle where it is high.
- `reg_sel`, out, 5, register index driven to the core.
- `dump_valid`, out, 1, dump entry valid this cycle.
- `dump_idx`, out, 5, index of the dumped entry.
- `dump_data`, out, 32, value of the dumped entry.
- `state`, out, 2, FSM state: 0 HALT, 1 RUN, 2 STEP, 3 DUMP.
- `icount`, out, CNT_W, retired-instruction count.
- `bp_hit`, out, 1, sticky flag: the last stop was caused by the breakpoint.

## Operation
- FSM states: HALT, RUN, STEP, DUMP. Reset state is HALT.
- HALT accepts commands with priority step > run > dump. Requests arriving in the same cycle are not queued; lower-priority ones are dropped. Any accepted command clears `bp_hit`.
  - `step` goes to STEP.
  - `run` goes to RUN and sets the internal `first` flag.
  - `dump` goes to DUMP, with `reg_sel` reset to 0.
- RUN:
  - `cpu_en = 1` unless the breakpoint matches. A match is `bp_en && PC == bp_addr && !first`.
  - On a match: `cpu_en = 0` in that same cycle, next state HALT, `bp_hit` set. The instruction at `bp_addr` is not executed.
  - `first` suppresses matching in the first RUN cycle only, so resuming at a breakpoint PC executes that instruction. `first` clears after that cycle.
  - `halt` sampled in RUN: the current cycle still executes (`cpu_en` follows the rule above), next state HALT. Breakpoint and halt in the same cycle: breakpoint wins (`cpu_en = 0`, `bp_hit = 1`).
  - `run`, `step` and `dump` are ignored in RUN.
- STEP:
  - `cpu_en = 1` for exactly one cycle, then HALT.
  - The breakpoint is ignored.
  - All commands are ignored.
- DUMP:
  - `cpu_en = 0`.
  - `reg_sel` increments 0..31, one per cycle.
  - Each cycle's `reg_data` is registered into `dump_data`, with `dump_idx = reg_sel`.
  - After `reg_sel = 31` is captured, `reg_sel` returns to 0 and the state goes to HALT.
  - All commands are ignored; the dump cannot be aborted except by `rst`.
- `cpu_en` is combinational from state, `first`, `PC` and the breakpoint compare. It is 0 whenever `rst = 1`.
- `icount` increments by 1 in every cycle with `cpu_en = 1` and wraps modulo 2^CNT_W. It is not cleared by commands.
- Reset values (applied on the first rising edge with `rst = 1`, overriding any in-progress operation including a dump):
  - `state` = HALT (0), `cpu_en` = 0, `reg_sel` = 0.
  - `dump_valid` = 0, `dump_idx` = 0, `dump_data` = 0.
  - `icount` = 0, `bp_hit` = 0, `first` = 0.
- The core's own `rst` is driven separately. `dbg_ctrl` never resets the core.

## Timing
- Command latency: a command pulse sampled at edge N changes `state` after edge N; `cpu_en` responds in cycle N+1.
- STEP: `cpu_en` is high for exactly cycle N+1; `state` returns to HALT after edge N+1.
- Breakpoint: the compare uses the current-cycle `PC`. `cpu_en` drops in the same cycle the match occurs (zero latency), so the core's `PC` holds `bp_addr`.
- DUMP: with the dump entered after edge N, `reg_sel = k` during cycle N+1+k. `dump_valid = 1` with `dump_idx = k` during cycle N+2+k, for k = 0..31.
- The dump therefore runs 32 consecutive valid cycles, and `state` = HALT from cycle N+33.
- `dump_valid` is high only in those cycles.

## Test plan
- Reset: assert `rst` mid-DUMP at `reg_sel` = 10 → next cycle `state` = 0, `cpu_en` = 0, `reg_sel` = 0, `dump_valid` = 0, `icount` = 0.
- Step: 3 `step` pulses spaced 4 cycles apart from PC 0x0 → `cpu_en` high exactly 3 single cycles, `icount` = 3, PC = 0xC, `state` = 0.
- Breakpoint: `bp_en` = 1, `bp_addr` = 0x10, `run` from PC 0x0 → `cpu_en` high 4 cycles, drops when PC = 0x10, `bp_hit` = 1, `icount` = 4.
  - Then `run` again → 0x10 executes (PC becomes 0x14) and `bp_hit` clears.
- Halt vs breakpoint: `halt` pulsed in the same cycle as the PC = `bp_addr` match → `cpu_en` = 0 that cycle, `bp_hit` = 1, `state` HALT.
- Dump: preload the RF with register i = 0x100 + i, then `dump` → 32 consecutive `dump_valid` cycles with `dump_idx` 0..31. `dump_data` is 0 for index 0 and 0x100 + i otherwise.
  - `run` pulsed mid-dump is ignored.
- Command priority and wrap: `step` and `run` together in HALT → STEP taken, one instruction only.
  - With CNT_W = 4, run 17 cycles → `icount` = 1.

Source files
------------

// File: rtl/dbg_ctrl.sv
// dbg_ctrl: run/halt/step/dump debug controller that gates the core through cpu_en.
// Latency: commands act one cycle after they are sampled; a breakpoint drops cpu_en in the same cycle.
// Backpressure: none; commands not accepted in the current state are dropped, a dump always runs 32 cycles.
module dbg_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             halt,
  input  logic             dump,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      PC,
  input  logic [31:0]      reg_data,
  output logic             cpu_en,
  output logic [4:0]       reg_sel,
  output logic             dump_valid,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] icount,
  output logic             bp_hit
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   first_q;
  logic   bp_match;
  logic   cmd_accept;
  logic   run_accept;
  logic   dump_accept;

  // The first RUN cycle never matches, so resuming from a breakpoint PC executes it.
  assign bp_match    = bp_en && (PC == bp_addr) && !first_q;
  assign cmd_accept  = (state_q == ST_HALT) && (run || step || dump);
  assign run_accept  = (state_q == ST_HALT) && run && !step;
  assign dump_accept = (state_q == ST_HALT) && dump && !run && !step;
  assign state       = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_HALT;
    else     state_q <= state_d;
  end

  // Next-state: HALT takes step > run > dump, RUN stops on breakpoint or halt
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (step)      state_d = ST_STEP;
        else if (run)  state_d = ST_RUN;
        else if (dump) state_d = ST_DUMP;
      end
      ST_RUN:  if (bp_match || halt) state_d = ST_HALT;
      ST_STEP: state_d = ST_HALT;
      ST_DUMP: if (reg_sel == 5'd31) state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // Output: core enable, combinational so a breakpoint stops the core in the matching cycle
  always_comb begin
    cpu_en = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN:  cpu_en = !bp_match;
        ST_STEP: cpu_en = 1'b1;
        default: cpu_en = 1'b0;
      endcase
    end
  end

  // First-cycle flag: set when run is accepted, cleared after the first RUN cycle
  always_ff @(posedge clk) begin
    if (rst)                     first_q <= 1'b0;
    else if (run_accept)         first_q <= 1'b1;
    else if (state_q == ST_RUN)  first_q <= 1'b0;
  end

  // Sticky breakpoint flag: cleared by any accepted command, set by a match in RUN
  always_ff @(posedge clk) begin
    if (rst)                                bp_hit <= 1'b0;
    else if (cmd_accept)                    bp_hit <= 1'b0;
    else if ((state_q == ST_RUN) && bp_match) bp_hit <= 1'b1;
  end

  // Register index walks 0..31 during DUMP and wraps back to 0 on the last entry
  always_ff @(posedge clk) begin
    if (rst)                     reg_sel <= 5'd0;
    else if (dump_accept)        reg_sel <= 5'd0;
    else if (state_q == ST_DUMP) reg_sel <= reg_sel + 5'd1;
  end

  // Dump capture: register the selected value one cycle after it is addressed
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_valid <= 1'b0;
      dump_idx   <= 5'd0;
      dump_data  <= 32'd0;
    end else begin
      dump_valid <= (state_q == ST_DUMP);
      if (state_q == ST_DUMP) begin
        dump_idx  <= reg_sel;
        dump_data <= reg_data;
      end
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)         icount <= '0;
    else if (cpu_en) icount <= icount + CNT_W'(1);
  end

endmodule
